// File: rtl/mode_counter_ctrl.sv
// mode_counter_ctrl
// Front-panel mode controller. It steps a counter up or down at a programmable
// tick rate, or passes the slide switches through to the 7-segment data bus.
// The raw buttons are synchronised and edge-detected before they act.
// When events coincide in one cycle, the mode edge acts first, then clear,
// then the count step.

module mode_counter_ctrl #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int MAX_COUNT = 9999,
  parameter int CNT_W     = 14,
  parameter int SW_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        btn,
  input  logic [SW_W-1:0]   sw,
  output logic [15:0]       led,
  output logic [CNT_W-1:0]  seg_data,
  output logic              tick,
  output logic              running
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_SW   = 2'b11;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

  // Button conditioning: two-flop synchroniser followed by a rising-edge detector
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic [2:0] prev_reg;
  logic [2:0] btn_edge;

  logic       mode_edge;
  logic       run_edge;
  logic       clr_edge;

  // Architectural state
  logic [1:0]       mode_reg,    mode_next;
  logic [CNT_W-1:0] count_reg,   count_next;
  logic [PRE_W-1:0] presc_reg,   presc_next;
  logic             running_reg, running_next;
  logic             tick_reg,    tick_next;

  // Next-state helpers
  logic             active;
  logic             terminal;
  logic [PRE_W-1:0] presc_inc;
  logic [CNT_W-1:0] count_up;
  logic [CNT_W-1:0] count_dn;
  logic [CNT_W-1:0] start_val;

  // Synchronise the asynchronous buttons and remember the last synchronised level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 3'b000;
      sync2_reg <= 3'b000;
      prev_reg  <= 3'b000;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign btn_edge  = sync2_reg & ~prev_reg;
  assign mode_edge = btn_edge[0];
  assign run_edge  = btn_edge[1];
  assign clr_edge  = btn_edge[2];

  // State register: mode, count, prescaler, run flag and the step marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg    <= MODE_IDLE;
      count_reg   <= '0;
      presc_reg   <= '0;
      running_reg <= 1'b1;
      tick_reg    <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      count_reg   <= count_next;
      presc_reg   <= presc_next;
      running_reg <= running_next;
      tick_reg    <= tick_next;
    end
  end

  // Next-state logic: mode sequencing, then clear, then the prescaled count step
  always_comb begin
    mode_next    = mode_reg;
    count_next   = count_reg;
    presc_next   = presc_reg;
    running_next = running_reg ^ run_edge;
    tick_next    = 1'b0;

    if (mode_edge) begin
      case (mode_reg)
        MODE_IDLE: mode_next = MODE_UP;
        MODE_UP:   mode_next = MODE_DOWN;
        MODE_DOWN: mode_next = MODE_SW;
        default:   mode_next = MODE_UP;
      endcase
    end

    active    = running_reg && ((mode_reg == MODE_UP) || (mode_reg == MODE_DOWN));
    terminal  = active && (presc_reg == PRE_LAST);
    presc_inc = terminal ? '0 : presc_reg + 1'b1;
    count_up  = (count_reg == CNT_MAX) ? '0 : count_reg + 1'b1;
    count_dn  = (count_reg == '0) ? CNT_MAX : count_reg - 1'b1;
    start_val = (mode_next == MODE_DOWN) ? CNT_MAX : '0;

    if ((mode_next == MODE_IDLE) || (mode_next == MODE_SW)) begin
      // Non-counting modes keep the datapath parked at zero
      count_next = '0;
      presc_next = '0;
    end else if (clr_edge) begin
      // Clear takes the start value of the mode being entered this cycle
      count_next = start_val;
      presc_next = '0;
    end else if (mode_edge && (mode_reg != MODE_UP)) begin
      // Fresh entry into UP from IDLE or SW_READ
      count_next = '0;
      presc_next = '0;
    end else if (active) begin
      // The prescaler keeps its phase across UP->DOWN. A step that coincides
      // with the mode edge is dropped because the mode edge has priority.
      presc_next = presc_inc;
      if (terminal && !mode_edge) begin
        tick_next  = 1'b1;
        count_next = (mode_reg == MODE_UP) ? count_up : count_dn;
      end
    end
  end

  // Output logic: register-driven status plus the switch/count display mux
  always_comb begin
    led     = {mode_reg, 14'(count_reg)};
    running = running_reg;
    tick    = tick_reg;
    case (mode_reg)
      MODE_UP, MODE_DOWN: seg_data = count_reg;
      MODE_SW:            seg_data = CNT_W'(sw);
      default:            seg_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mode_counter_ctrl.sv
// Testbench for mode_counter_ctrl with a small tick period and wrap limit.
// Expected values are queued when stimulus is applied and popped on observation.

module tb_mode_counter_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int MAX_COUNT = 9;
  localparam int CNT_W     = 14;
  localparam int SW_W      = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       btn = 3'b000;
  logic [SW_W-1:0]  sw = '0;
  logic [15:0]      led;
  logic [CNT_W-1:0] seg_data;
  logic             tick;
  logic             running;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  mode_counter_ctrl #(
    .TICK_DIV (TICK_DIV),
    .MAX_COUNT(MAX_COUNT),
    .CNT_W    (CNT_W),
    .SW_W     (SW_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .sw      (sw),
    .led     (led),
    .seg_data(seg_data),
    .tick    (tick),
    .running (running)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and sample 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Step until tick is seen; cycles = -1 if the budget runs out
  task automatic wait_tick(input int budget, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = -1;
    for (int i = 1; i <= budget && !seen; i++) begin
      step();
      if (tick === 1'b1) begin
        seen = 1'b1;
        cycles = i;
      end
    end
    $display("tick wait: %0d cycles, mode=%0d count=%0d", cycles, led[15:14], led[13:0]);
  endtask

  // Pulse buttons for one cycle; returns just after the edge where the state reacts
  task automatic press_apply(input logic [2:0] mask);
    btn = mask;
    step();
    btn = 3'b000;
    step();
    step();
    $display("press %b: mode=%0d count=%0d running=%0b", mask, led[15:14], led[13:0], running);
  endtask

  task automatic do_reset();
    btn = 3'b000;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [31:0] obs;
    #2 reset = 1'b1;
    #1;
    e.name = "reset_led";     e.val = 32'h0; exp_q.push_back(e);
    e.name = "reset_seg";     e.val = 32'h0; exp_q.push_back(e);
    e.name = "reset_tick";    e.val = 32'h0; exp_q.push_back(e);
    e.name = "reset_running"; e.val = 32'h1; exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      obs = (i == 0) ? 32'(led) : (i == 1) ? 32'(seg_data) : (i == 2) ? 32'(tick) : 32'(running);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val);
      end
    end
    $display("reset applied: led=%h seg=%h running=%0b", led, seg_data, running);
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_mode_sequence();
    logic [1:0] seq [4];
    logic [1:0] prev_mode;
    exp_t       e;
    seq = '{2'd1, 2'd2, 2'd3, 2'd1};
    prev_mode = 2'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e.name = "mode_step"; e.val = 32'(seq[i]); exp_q.push_back(e);
      btn = 3'b001;
      step();
      step();
      n_checks++;
      if (led[15:14] !== prev_mode) begin
        n_errors++;
        $display("FAIL mode_early: press %0d got %0d expected %0d", i, led[15:14], prev_mode);
      end
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (32'(led[15:14]) !== e.val) begin
        n_errors++;
        $display("FAIL %s: press %0d got %0d expected %0d", e.name, i, led[15:14], e.val);
      end
      repeat (7) step();
      n_checks++;
      if (led[15:14] !== seq[i]) begin
        n_errors++;
        $display("FAIL mode_held: press %0d got %0d expected %0d", i, led[15:14], seq[i]);
      end
      btn = 3'b000;
      repeat (5) step();
      $display("mode press %0d: mode=%0d", i, led[15:14]);
      prev_mode = seq[i];
    end
  endtask

  task automatic test_up_count();
    exp_t e;
    int   c;
    do_reset();
    press_apply(3'b001);
    n_checks++;
    if (led !== 16'h4000) begin
      n_errors++;
      $display("FAIL up_entry: got %h expected %h", led, 16'h4000);
    end
    for (int k = 1; k <= 10; k++) begin
      e.name = "up_count"; e.val = 32'(k % (MAX_COUNT + 1)); exp_q.push_back(e);
    end
    for (int k = 1; k <= 10; k++) begin
      wait_tick(2 * TICK_DIV, c);
      n_checks++;
      if (c != TICK_DIV) begin
        n_errors++;
        $display("FAIL up_tick_spacing: tick %0d after %0d cycles expected %0d", k, c, TICK_DIV);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (32'(led[13:0]) !== e.val) begin
        n_errors++;
        $display("FAIL %s: tick %0d got %0d expected %0d", e.name, k, led[13:0], e.val);
      end
      n_checks++;
      if (32'(seg_data) !== e.val) begin
        n_errors++;
        $display("FAIL up_seg: tick %0d got %0d expected %0d", k, seg_data, e.val);
      end
    end
  endtask

  task automatic test_up_down();
    exp_t e;
    int   c;
    int   v;
    do_reset();
    press_apply(3'b001);
    for (int k = 0; k < 5; k++) wait_tick(2 * TICK_DIV, c);
    n_checks++;
    if (led[13:0] !== 14'd5) begin
      n_errors++;
      $display("FAIL ud_reach5: got %0d expected 5", led[13:0]);
    end
    // Mode edge lands 3 cycles after the tick; the phase carries over
    press_apply(3'b001);
    n_checks++;
    if (led !== {2'b10, 14'd5}) begin
      n_errors++;
      $display("FAIL ud_enter_down: got %h expected %h", led, {2'b10, 14'd5});
    end
    wait_tick(2 * TICK_DIV, c);
    n_checks++;
    if (c != TICK_DIV - 3 || led[13:0] !== 14'd4) begin
      n_errors++;
      $display("FAIL ud_first_down: cycles %0d count %0d expected cycles %0d count 4", c, led[13:0], TICK_DIV - 3);
    end
    press_apply(3'b100);
    n_checks++;
    if (led !== {2'b10, 14'(MAX_COUNT)}) begin
      n_errors++;
      $display("FAIL ud_clear_down: got %h expected %h", led, {2'b10, 14'(MAX_COUNT)});
    end
    v = MAX_COUNT;
    for (int k = 0; k < MAX_COUNT + 1; k++) begin
      v = (v == 0) ? MAX_COUNT : v - 1;
      e.name = "down_count"; e.val = 32'(v); exp_q.push_back(e);
    end
    for (int k = 0; k < MAX_COUNT + 1; k++) begin
      wait_tick(2 * TICK_DIV, c);
      e = exp_q.pop_front();
      n_checks++;
      if (c != TICK_DIV || 32'(led[13:0]) !== e.val) begin
        n_errors++;
        $display("FAIL %s: step %0d cycles %0d got %0d expected %0d", e.name, k, c, led[13:0], e.val);
      end
    end
  endtask

  task automatic test_pause();
    int c;
    int ticks_seen;
    do_reset();
    press_apply(3'b001);
    repeat (3) step();
    btn = 3'b010;
    step();
    n_checks++;
    if (tick !== 1'b1 || led[13:0] !== 14'd1) begin
      n_errors++;
      $display("FAIL pause_pre_tick: tick %0b count %0d expected tick 1 count 1", tick, led[13:0]);
    end
    btn = 3'b000;
    step();
    step();
    n_checks++;
    if (running !== 1'b0) begin
      n_errors++;
      $display("FAIL pause_running: got %0b expected 0", running);
    end
    ticks_seen = 0;
    repeat (50) begin
      step();
      if (tick === 1'b1) ticks_seen++;
    end
    n_checks++;
    if (ticks_seen != 0 || led[13:0] !== 14'd1 || running !== 1'b0) begin
      n_errors++;
      $display("FAIL pause_hold: ticks %0d count %0d running %0b expected 0/1/0", ticks_seen, led[13:0], running);
    end
    press_apply(3'b010);
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++;
      $display("FAIL resume_running: got %0b expected 1", running);
    end
    wait_tick(2 * TICK_DIV, c);
    n_checks++;
    if (c != 2 || led[13:0] !== 14'd2) begin
      n_errors++;
      $display("FAIL resume_phase: cycles %0d count %0d expected cycles 2 count 2", c, led[13:0]);
    end
  endtask

  task automatic test_clear_terminal();
    int c;
    do_reset();
    press_apply(3'b001);
    step();
    btn = 3'b100;
    step();
    btn = 3'b000;
    step();
    step();
    n_checks++;
    if (led !== 16'h4000 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_terminal: led %h tick %0b expected 4000 tick 0", led, tick);
    end
    wait_tick(2 * TICK_DIV, c);
    n_checks++;
    if (c != TICK_DIV || led[13:0] !== 14'd1) begin
      n_errors++;
      $display("FAIL clear_next_tick: cycles %0d count %0d expected %0d / 1", c, led[13:0], TICK_DIV);
    end
    press_apply(3'b101);
    n_checks++;
    if (led !== {2'b10, 14'(MAX_COUNT)}) begin
      n_errors++;
      $display("FAIL mode_and_clear: got %h expected %h", led, {2'b10, 14'(MAX_COUNT)});
    end
    wait_tick(2 * TICK_DIV, c);
    n_checks++;
    if (c != TICK_DIV || 32'(led[13:0]) !== 32'(MAX_COUNT - 1)) begin
      n_errors++;
      $display("FAIL mode_clear_step: cycles %0d count %0d expected %0d / %0d", c, led[13:0], TICK_DIV, MAX_COUNT - 1);
    end
  endtask

  task automatic test_sw_read();
    int c;
    int ticks_seen;
    do_reset();
    sw = 8'hA5;
    press_apply(3'b001);
    press_apply(3'b001);
    press_apply(3'b001);
    n_checks++;
    if (led !== 16'hC000) begin
      n_errors++;
      $display("FAIL sw_led: got %h expected C000", led);
    end
    n_checks++;
    if (seg_data !== 14'h00A5) begin
      n_errors++;
      $display("FAIL sw_seg: got %h expected 00A5", seg_data);
    end
    ticks_seen = 0;
    repeat (20) begin
      step();
      if (tick === 1'b1) ticks_seen++;
    end
    n_checks++;
    if (ticks_seen != 0) begin
      n_errors++;
      $display("FAIL sw_no_tick: saw %0d ticks expected 0", ticks_seen);
    end
    sw = 8'h3C;
    #1;
    n_checks++;
    if (seg_data !== 14'h003C) begin
      n_errors++;
      $display("FAIL sw_comb: got %h expected 003C", seg_data);
    end
    press_apply(3'b001);
    n_checks++;
    if (led !== 16'h4000) begin
      n_errors++;
      $display("FAIL sw_to_up: got %h expected 4000", led);
    end
    wait_tick(2 * TICK_DIV, c);
    n_checks++;
    if (c != TICK_DIV || led[13:0] !== 14'd1) begin
      n_errors++;
      $display("FAIL sw_up_first_tick: cycles %0d count %0d expected %0d / 1", c, led[13:0], TICK_DIV);
    end
  endtask

  task automatic test_async_reset();
    int c;
    do_reset();
    press_apply(3'b001);
    press_apply(3'b001);
    wait_tick(2 * TICK_DIV, c);
    press_apply(3'b010);
    n_checks++;
    if (running !== 1'b0 || led[15:14] !== 2'b10) begin
      n_errors++;
      $display("FAIL pre_reset_state: running %0b mode %0d expected 0 / 2", running, led[15:14]);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (led !== 16'h0000 || seg_data !== '0 || running !== 1'b1 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: led %h seg %h running %0b tick %0b expected 0/0/1/0", led, seg_data, running, tick);
    end
    step();
    reset = 1'b0;
    repeat (3) step();
    n_checks++;
    if (led !== 16'h0000 || running !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_idle: led %h running %0b expected 0000 / 1", led, running);
    end
    $display("async reset done: led=%h running=%0b", led, running);
  endtask

  initial begin
    test_reset();
    test_mode_sequence();
    test_up_count();
    test_up_down();
    test_pause();
    test_clear_terminal();
    test_sw_read();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
